// File: rtl/wb_timer.sv
// rtl/wb_timer.sv - Wishbone timer/compare peripheral with prescaler, auto-reload and level interrupt
//
// Purpose:
//   Prescaled 32-bit up-counter with a compare register. On a compare match
//   the MATCH flag is set and the counter either reloads to 0 (AUTORELOAD)
//   or stops (EN cleared). irq_o follows MATCH & IRQEN one cycle later.
//   Single-beat Wishbone slave with a registered ack/err.
//
// Register map (byte offsets, word aligned):
//   0x00 CTRL      RW  bit0 EN, bit1 AUTORELOAD, bit2 IRQEN
//   0x04 PRESCALE  RW  [PRESCALE_W-1:0]
//   0x08 COUNT     RW
//   0x0C COMPARE   RW  (resets to 0xFFFFFFFF)
//   0x10 STATUS    W1C bit0 MATCH, bit1 CAPF (capture build only)
//   0x14 CAPTURE   RO  (capture build only, otherwise error)
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-high
//   capture_i  capture strobe, asynchronous (only with WB_TIMER_CAPTURE_EN)
//   wb_cyc_i   cycle valid
//   wb_stb_i   strobe
//   wb_we_i    write enable
//   wb_adr_i   byte address, low ADDR_LSB_W bits decoded
//   wb_sel_i   byte lane enables for writes
//   wb_dat_i   write data
//   wb_dat_o   read data, valid while wb_ack_o is high
//   wb_ack_o   normal termination
//   wb_err_o   error termination (misaligned or unmapped offset)
//   wb_rty_o   retry, always 0
//   irq_o      timer interrupt, level
//
// Optional feature macro: WB_TIMER_CAPTURE_EN

module wb_timer #(
    parameter int ADDR_LSB_W = 5,
    parameter int PRESCALE_W = 16
) (
    input  logic        clk,
    input  logic        rst,
`ifdef WB_TIMER_CAPTURE_EN
    input  logic        capture_i,
`endif
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_rty_o,
    output logic        irq_o
);

    localparam logic [ADDR_LSB_W-1:0] OFF_CTRL     = ADDR_LSB_W'(8'h00);
    localparam logic [ADDR_LSB_W-1:0] OFF_PRESCALE = ADDR_LSB_W'(8'h04);
    localparam logic [ADDR_LSB_W-1:0] OFF_COUNT    = ADDR_LSB_W'(8'h08);
    localparam logic [ADDR_LSB_W-1:0] OFF_COMPARE  = ADDR_LSB_W'(8'h0C);
    localparam logic [ADDR_LSB_W-1:0] OFF_STATUS   = ADDR_LSB_W'(8'h10);
`ifdef WB_TIMER_CAPTURE_EN
    localparam logic [ADDR_LSB_W-1:0] OFF_CAPTURE  = ADDR_LSB_W'(8'h14);
`endif

    // Register state
    logic                  ctrl_en;
    logic                  ctrl_autoreload;
    logic                  ctrl_irqen;
    logic [PRESCALE_W-1:0] prescale;
    logic [PRESCALE_W-1:0] presc_cnt;
    logic [31:0]           count;
    logic [31:0]           compare;
    logic                  match;
`ifdef WB_TIMER_CAPTURE_EN
    logic [31:0]           capture;
    logic                  capf;
    logic [2:0]            cap_sync;
    logic                  cap_rise;
`endif

    // Bus decode
    logic [ADDR_LSB_W-1:0] offset;
    logic                  req;
    logic                  bad;
    logic                  hit_ctrl;
    logic                  hit_prescale;
    logic                  hit_count;
    logic                  hit_compare;
    logic                  hit_status;
    logic                  hit_capture;
    logic [31:0]           rd_data;
    logic [31:0]           wdata;
    logic                  wr;
    logic                  clr_match;
    logic                  clr_capf;

    logic [31:0]           ctrl_word;
    logic [31:0]           status_word;

    // Timer events
    logic                  tick;
    logic                  is_match;

    // Upper address bits are decoded upstream by the segment select.
    logic unused_adr;
    assign unused_adr = &{1'b0, wb_adr_i[31:ADDR_LSB_W]};

    assign offset   = wb_adr_i[ADDR_LSB_W-1:0];
    assign req      = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
    assign wb_rty_o = 1'b0;

    assign ctrl_word = {29'd0, ctrl_irqen, ctrl_autoreload, ctrl_en};
`ifdef WB_TIMER_CAPTURE_EN
    assign status_word = {30'd0, capf, match};
`else
    assign status_word = {31'd0, match};
`endif

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  be
    );
        logic [31:0] res;
        for (int n = 0; n < 4; n++) begin
            res[8*n +: 8] = be[n] ? new_val[8*n +: 8] : old_val[8*n +: 8];
        end
        return res;
    endfunction

    always_comb begin
        hit_ctrl     = 1'b0;
        hit_prescale = 1'b0;
        hit_count    = 1'b0;
        hit_compare  = 1'b0;
        hit_status   = 1'b0;
        hit_capture  = 1'b0;
        rd_data      = 32'd0;
        if (offset[1:0] == 2'b00) begin
            if (offset == OFF_CTRL) begin
                hit_ctrl = 1'b1;
                rd_data  = ctrl_word;
            end else if (offset == OFF_PRESCALE) begin
                hit_prescale = 1'b1;
                rd_data      = 32'(prescale);
            end else if (offset == OFF_COUNT) begin
                hit_count = 1'b1;
                rd_data   = count;
            end else if (offset == OFF_COMPARE) begin
                hit_compare = 1'b1;
                rd_data     = compare;
            end else if (offset == OFF_STATUS) begin
                hit_status = 1'b1;
                rd_data    = status_word;
            end
`ifdef WB_TIMER_CAPTURE_EN
            else if (offset == OFF_CAPTURE) begin
                hit_capture = 1'b1;
                rd_data     = capture;
            end
`endif
        end
        bad = ~(hit_ctrl | hit_prescale | hit_count | hit_compare | hit_status | hit_capture);
    end

    // Unselected lanes keep the register's current value. A write with no
    // lanes enabled is still acked but must not block a concurrent tick.
    assign wdata     = merge_bytes(rd_data, wb_dat_i, wb_sel_i);
    assign wr        = req & wb_we_i & ~bad & (|wb_sel_i);
    assign clr_match = wr & hit_status & wb_sel_i[0] & wb_dat_i[0];
    assign clr_capf  = wr & hit_status & wb_sel_i[0] & wb_dat_i[1];

    assign tick     = ctrl_en & (presc_cnt == prescale);
    assign is_match = (count == compare);

`ifdef WB_TIMER_CAPTURE_EN
    // cap_sync[1:0] is the two-flop synchroniser, cap_sync[2] the edge history.
    assign cap_rise = cap_sync[1] & ~cap_sync[2];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_en         <= 1'b0;
            ctrl_autoreload <= 1'b0;
            ctrl_irqen      <= 1'b0;
            prescale        <= '0;
            presc_cnt       <= '0;
            count           <= 32'd0;
            compare         <= 32'hFFFF_FFFF;
            match           <= 1'b0;
            irq_o           <= 1'b0;
            wb_ack_o        <= 1'b0;
            wb_err_o        <= 1'b0;
            wb_dat_o        <= 32'd0;
        end else begin
            // Prescaler: wraps to 0 on tick, parked at 0 while disabled.
            if (!ctrl_en || tick) begin
                presc_cnt <= '0;
            end else begin
                presc_cnt <= presc_cnt + 1'b1;
            end

            // CTRL: a bus write overrides the one-shot stop on match.
            if (wr && hit_ctrl) begin
                ctrl_irqen      <= wdata[2];
                ctrl_autoreload <= wdata[1];
                ctrl_en         <= wdata[0];
            end else if (tick && is_match && !ctrl_autoreload) begin
                ctrl_en <= 1'b0;
            end

            if (wr && hit_prescale) begin
                prescale <= wdata[PRESCALE_W-1:0];
            end

            // COUNT: a bus write overrides the tick update.
            if (wr && hit_count) begin
                count <= wdata;
            end else if (tick) begin
                if (is_match) begin
                    if (ctrl_autoreload) begin
                        count <= 32'd0;
                    end
                end else begin
                    count <= count + 32'd1;
                end
            end

            if (wr && hit_compare) begin
                compare <= wdata;
            end

            // Set beats a concurrent W1C.
            match <= (tick & is_match) | (match & ~clr_match);

            irq_o <= match & ctrl_irqen;

            wb_ack_o <= req & ~bad;
            wb_err_o <= req & bad;
            if (req) begin
                wb_dat_o <= bad ? 32'd0 : rd_data;
            end
        end
    end

`ifdef WB_TIMER_CAPTURE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_sync <= 3'd0;
            capture  <= 32'd0;
            capf     <= 1'b0;
        end else begin
            cap_sync <= {cap_sync[1:0], capture_i};
            if (cap_rise) begin
                capture <= count;
            end
            capf <= cap_rise | (capf & ~clr_capf);
        end
    end
`endif

endmodule

// File: tb/tb_wb_timer.sv
// tb/tb_wb_timer.sv - scoreboard bench for wb_timer with a behavioural timer model
module tb_wb_timer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        ack;
    logic        err;
    logic        rty;
    logic        irq;
    logic        cap = 1'b0;

    always #5 clk = ~clk;

    wb_timer dut (
        .clk      (clk),
        .rst      (rst),
`ifdef WB_TIMER_CAPTURE_EN
        .capture_i(cap),
`endif
        .wb_cyc_i (cyc),
        .wb_stb_i (stb),
        .wb_we_i  (we),
        .wb_adr_i (adr),
        .wb_sel_i (sel),
        .wb_dat_i (dat_i),
        .wb_dat_o (dat_o),
        .wb_ack_o (ack),
        .wb_err_o (err),
        .wb_rty_o (rty),
        .irq_o    (irq)
    );

    typedef struct {
        logic [31:0] adr;
        logic        is_err;
        logic        chk;
        logic [31:0] dat;
    } resp_t;

    resp_t resp_q[$];
    logic  irq_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic        m_en, m_ar, m_ie, m_match, m_busy;
    logic [15:0] m_pre, m_pc;
    logic [31:0] m_cnt, m_cmp;

    logic        ovr_en = 1'b0;
    logic [31:0] ovr_val = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a response.
    always @(negedge clk) begin
        resp_t r;
        logic  e;
        if (irq_q.size() != 0) begin
            e = irq_q.pop_front();
            check("irq_o", {31'd0, irq}, {31'd0, e});
            check("rty_o", {31'd0, rty}, 32'd0);
        end
        if (ack || err) begin
            if (resp_q.size() == 0) begin
                check("unexpected_response", {30'd0, ack, err}, 32'd0);
            end else begin
                r = resp_q.pop_front();
                check($sformatf("resp_kind@%08h", r.adr), {30'd0, ack, err},
                      r.is_err ? 32'd1 : 32'd2);
                if (r.is_err) begin
                    check($sformatf("err_data@%08h", r.adr), dat_o, 32'd0);
                end else if (r.chk) begin
                    check($sformatf("read_data@%08h", r.adr), dat_o, r.dat);
                end
            end
        end else if (resp_q.size() != 0) begin
            r = resp_q.pop_front();
            check($sformatf("missing_response@%08h", r.adr), {30'd0, ack, err},
                  r.is_err ? 32'd1 : 32'd2);
        end
    end

    task automatic model_reset();
        m_en = 0; m_ar = 0; m_ie = 0; m_match = 0; m_busy = 0;
        m_pre = 0; m_pc = 0; m_cnt = 0; m_cmp = 32'hFFFF_FFFF;
    endtask

    // One bus cycle: drive inputs, advance the model over the coming edge,
    // then queue what the DUT must show after that edge.
    task automatic cycle(input logic c, input logic s, input logic w, input logic [31:0] a,
                         input logic [3:0] be, input logic [31:0] d, input logic r);
        resp_t       rr;
        logic        push_r, exp_irq, req, tick, hit, bad;
        logic [4:0]  off;
        logic [31:0] cur, mrg, n_cnt, n_cmp;
        logic [15:0] n_pre, n_pc;
        logic        n_en, n_ar, n_ie, n_match;
        cyc = c; stb = s; we = w; adr = a; sel = be; dat_i = d; rst = r;
        push_r = 0;
        exp_irq = 0;
        rr.adr = a; rr.is_err = 0; rr.chk = 0; rr.dat = 0;
        if (r) begin
            model_reset();
        end else begin
            req = c && s && !m_busy;
            off = a[4:0];
            bad = 1;
            cur = 0;
            if (a[1:0] == 2'b00) begin
                case (off)
                    5'h00: begin bad = 0; cur = {29'd0, m_ie, m_ar, m_en}; end
                    5'h04: begin bad = 0; cur = {16'd0, m_pre}; end
                    5'h08: begin bad = 0; cur = m_cnt; end
                    5'h0C: begin bad = 0; cur = m_cmp; end
                    5'h10: begin bad = 0; cur = {31'd0, m_match}; end
`ifdef WB_TIMER_CAPTURE_EN
                    5'h14: begin bad = 0; cur = 0; end
`endif
                    default: ;
                endcase
            end
            tick = m_en && (m_pc == m_pre);
            hit  = tick && (m_cnt == m_cmp);
            n_cnt = m_cnt; n_cmp = m_cmp; n_pre = m_pre;
            n_en = m_en; n_ar = m_ar; n_ie = m_ie;
            n_pc = (m_en && !tick) ? m_pc + 16'd1 : 16'd0;
            if (tick) begin
                if (hit) begin
                    if (m_ar) n_cnt = 0;
                    else n_en = 0;
                end else begin
                    n_cnt = m_cnt + 32'd1;
                end
            end
            n_match = m_match || hit;
            exp_irq = m_match && m_ie;
            if (req && w && !bad && be != 4'd0) begin
                for (int b = 0; b < 4; b++) mrg[8*b +: 8] = be[b] ? d[8*b +: 8] : cur[8*b +: 8];
                case (off)
                    5'h00: {n_ie, n_ar, n_en} = mrg[2:0];
                    5'h04: n_pre = mrg[15:0];
                    5'h08: n_cnt = mrg;
                    5'h0C: n_cmp = mrg;
                    5'h10: if (be[0] && d[0]) n_match = hit;
                    default: ;
                endcase
            end
            if (req) begin
                push_r    = 1;
                rr.is_err = bad;
                rr.chk    = !w && !bad;
                rr.dat    = ovr_en ? ovr_val : cur;
            end
            m_cnt = n_cnt; m_cmp = n_cmp; m_pre = n_pre; m_pc = n_pc;
            m_en = n_en; m_ar = n_ar; m_ie = n_ie; m_match = n_match;
            m_busy = req;
        end
        @(posedge clk);
        #1;
        irq_q.push_back(exp_irq);
        if (push_r) resp_q.push_back(rr);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 32'd0, 4'd0, 32'd0, 0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        cycle(1, 1, 1, a, 4'hF, d, 0);
        idle(1);
    endtask

    task automatic rd(input logic [31:0] a);
        cycle(1, 1, 0, a, 4'hF, 32'd0, 0);
        idle(1);
    endtask

    // Read whose expected data is a fixed value rather than the model's.
    task automatic rdc(input logic [31:0] a, input logic [31:0] v);
        ovr_en = 1; ovr_val = v;
        cycle(1, 1, 0, a, 4'hF, 32'd0, 0);
        ovr_en = 0;
        idle(1);
    endtask

    initial begin
        logic [31:0] a, d, up;
        logic [3:0]  be;
        int          pick;
        model_reset();
        cyc = 0; stb = 0; we = 0; adr = 0; sel = 0; dat_i = 0; rst = 1;
        @(posedge clk);
        #1;
        cycle(0, 0, 0, 32'd0, 4'd0, 32'd0, 1);
        cycle(0, 0, 0, 32'd0, 4'd0, 32'd0, 1);

        // Reset values
        rdc(32'h0C, 32'hFFFF_FFFF);
        rdc(32'h10, 32'd0);
        rdc(32'h00, 32'd0);
        rdc(32'h08, 32'd0);

        // Prescaled auto-reload with interrupt
        wr(32'h04, 32'd3);
        wr(32'h0C, 32'd5);
        wr(32'h00, 32'd7);
        for (int i = 0; i < 12; i++) begin
            rd(32'h08);
            idle(2);
        end
        rd(32'h10);
        wr(32'h10, 32'd1);
        idle(3);
        wr(32'h00, 32'd0);
        wr(32'h10, 32'd1);
        rdc(32'h10, 32'd0);

        // One-shot stop without interrupt
        wr(32'h08, 32'd0);
        wr(32'h0C, 32'd2);
        wr(32'h04, 32'd0);
        wr(32'h00, 32'd1);
        idle(10);
        rdc(32'h08, 32'd2);
        rdc(32'h00, 32'd0);
        rdc(32'h10, 32'd1);
        wr(32'h10, 32'd1);

        // Counter wrap without match
        wr(32'h08, 32'hFFFF_FFFF);
        wr(32'h0C, 32'h10);
        wr(32'h00, 32'd1);
        rdc(32'h08, 32'd0);
        rdc(32'h10, 32'd0);
        wr(32'h00, 32'd0);

        // Error terminations and byte lanes
        rd(32'h02);
        wr(32'h18, 32'h1234_5678);
        rd(32'h14);
        rd(32'h1F);
        wr(32'h0C, 32'hFFFF_FFFF);
        cycle(1, 1, 1, 32'h0C, 4'b0010, 32'hAABB_CCDD, 0);
        idle(1);
        rdc(32'h0C, 32'hFFFF_CCFF);
        cycle(1, 1, 1, 32'h0C, 4'b0000, 32'h0, 0);
        idle(1);
        rdc(32'h0C, 32'hFFFF_CCFF);

        // Strobe held for four cycles
        for (int i = 0; i < 4; i++) cycle(1, 1, 0, 32'h0C, 4'hF, 32'd0, 0);
        idle(1);

        // COUNT write coincident with a tick
        wr(32'h04, 32'd0);
        wr(32'h0C, 32'h1000);
        wr(32'h00, 32'd1);
        wr(32'h08, 32'd7);
        rdc(32'h08, 32'd8);
        wr(32'h00, 32'd0);

        // Reset during a request: no response
        cycle(1, 1, 0, 32'h08, 4'hF, 32'd0, 1);
        idle(1);
        rdc(32'h0C, 32'hFFFF_FFFF);

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            pick = $urandom_range(0, 10);
            up = $urandom();
            case (pick)
                0, 1:    a = 32'h00;
                2:       a = 32'h04;
                3, 4:    a = 32'h08;
                5:       a = 32'h0C;
                6, 7:    a = 32'h10;
                8:       a = 32'h14;
                9:       a = 32'h18 + 32'($urandom_range(0, 1) * 4);
                default: a = 32'($urandom_range(0, 31));
            endcase
            a = (up & 32'hFFFF_FFE0) | a;
            case (a[4:0])
                5'h00:   d = 32'($urandom_range(0, 7));
                5'h04:   d = 32'($urandom_range(0, 3));
                5'h08:   d = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : 32'($urandom_range(0, 20));
                5'h0C:   d = 32'($urandom_range(0, 20));
                default: d = $urandom();
            endcase
            be = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            cycle(1, 1, 1'($urandom_range(0, 1)), a, be, d, 0);
            idle($urandom_range(1, 4));
        end

        idle(3);
        check("scoreboard_drained", 32'(resp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
